step_sequencer: RTL

STEP_SEQUENCER -- requirements
Module: step_sequencer

---
 rtl/step_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: control-step sequencer for a multi-cycle instruction engine.
// Walks Step through 1..NUM_STEPS per instruction, supports stalls, early
// completion from step 3 onwards, halting after the current instruction, and
// counts retired instructions.
module step_sequencer #(
  parameter int NUM_STEPS = 5,
  parameter int COUNT_W   = 16
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 Run,
  input  logic                 Stall,
  input  logic                 EarlyDone,
  input  logic                 Halt,
  output logic [2:0]           Step,
  output logic [NUM_STEPS-1:0] T,
  output logic                 Advance,
  output logic                 InstrDone,
  output logic                 Busy,
  output logic                 Halted,
  output logic [COUNT_W-1:0]   InstrCount
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS);
  localparam logic [2:0] FIRST_EARLY = 3'd3;

  state_t               state_reg;
  logic [2:0]           step_reg;
  logic                 instr_done_reg;
  logic [COUNT_W-1:0]   count_reg;
  logic                 completion;

  // An instruction retires on an unstalled RUN cycle at the last step, or
  // earlier when EarlyDone is raised at step 3 or later.
  assign completion = (state_reg == RUN) && !Stall &&
                      ((step_reg == LAST_STEP) ||
                       (EarlyDone && (step_reg >= FIRST_EARLY)));

  // Sequencer state, step counter, retirement pulse and retired count.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg      <= IDLE;
      step_reg       <= 3'd0;
      instr_done_reg <= 1'b0;
      count_reg      <= '0;
    end else begin
      instr_done_reg <= 1'b0;
      case (state_reg)
        IDLE, HALTED: begin
          if (Run) begin
            state_reg <= RUN;
            step_reg  <= 3'd1;
          end else begin
            step_reg  <= 3'd0;
          end
        end
        RUN: begin
          if (completion) begin
            instr_done_reg <= 1'b1;
            count_reg      <= count_reg + COUNT_W'(1);
            if (Halt) begin
              state_reg <= HALTED;
              step_reg  <= 3'd0;
            end else begin
              step_reg  <= 3'd1;
            end
          end else if (!Stall) begin
            step_reg <= step_reg + 3'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          step_reg  <= 3'd0;
        end
      endcase
    end
  end

  // One-hot step decode: T[gi] is set when Step equals gi+1.
  for (genvar gi = 0; gi < NUM_STEPS; gi++) begin : g_tdec
    assign T[gi] = (step_reg == 3'(gi + 1));
  end

  assign Step       = step_reg;
  assign Advance    = (step_reg != 3'd0) && !Stall;
  assign InstrDone  = instr_done_reg;
  assign Busy       = (state_reg == RUN);
  assign Halted     = (state_reg == HALTED);
  assign InstrCount = count_reg;

endmodule
